// File: rtl/reglk_init_seq_if.sv
// reglk_init_seq_if: simple en/we/addr/wdata/rdata slave port between the lock-word
// initiator (master) and the register-lock bank (slave).
interface reglk_init_seq_if #(
    parameter int AW = 64
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [63:0]   wdata;
    logic          gnt;
    logic          rvalid;
    logic [63:0]   rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/reglk_init_seq.sv
// reglk_init_seq: boot-time initiator writing NUM_WORDS lock words to the lock bank;
// readback verification is built only with REGLK_INIT_VERIFY_EN defined.
module reglk_init_seq #(
    parameter int                        AXI_ADDR_WIDTH = 64,
    parameter int                        NUM_WORDS      = 6,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [32*NUM_WORDS-1:0] lock_words_i,
    reglk_init_seq_if.master       bus,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic                   err_timeout_o,
    output logic [4:0]             err_idx_o
);
    typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, DONE, ERROR} state_e;

    localparam logic [4:0]  LAST_IDX = 5'(NUM_WORDS - 1);
    localparam logic [15:0] CNT_LIM  = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d, err_idx_q, err_idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_to_q, err_to_d;
    logic        capture, last, expired, waiting, req, we;
    logic [31:0] words_q [NUM_WORDS];
    logic [31:0] cur_word;

    always_comb begin
        cur_word = '0;
        for (int k = 0; k < NUM_WORDS; k++)
            if (idx_q == 5'(k)) cur_word = words_q[k];
    end

    assign last    = idx_q == LAST_IDX;
    assign expired = cnt_q == CNT_LIM;

`ifdef REGLK_INIT_VERIFY_EN
    assign waiting = ((state_q == WR || state_q == RD_REQ) && !bus.gnt) ||
                     (state_q == RD_WAIT && !bus.rvalid);
`else
    logic unused_rd;
    assign unused_rd = ^{bus.rvalid, bus.rdata};
    assign waiting   = state_q == WR && !bus.gnt;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = '0;
        err_to_d  = err_to_q;
        err_idx_d = err_idx_q;
        capture   = 1'b0;
        case (state_q)
            IDLE, DONE, ERROR: if (start_i) begin
                capture   = 1'b1;
                state_d   = WR;
                idx_d     = '0;
                err_to_d  = 1'b0;
                err_idx_d = '0;
            end
            WR: if (bus.gnt) begin
`ifdef REGLK_INIT_VERIFY_EN
                state_d = last ? RD_REQ : WR;
`else
                state_d = last ? DONE : WR;
`endif
                idx_d   = last ? 5'd0 : idx_q + 5'd1;
            end
`ifdef REGLK_INIT_VERIFY_EN
            RD_REQ: if (bus.gnt) state_d = RD_WAIT;
            RD_WAIT: if (bus.rvalid) begin
                if (bus.rdata != {32'b0, cur_word}) begin
                    state_d   = ERROR;
                    err_to_d  = 1'b0;
                    err_idx_d = idx_q;
                end else begin
                    state_d = last ? DONE : RD_REQ;
                    idx_d   = last ? idx_q : idx_q + 5'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        // a grant/valid in the limit cycle never reaches here, so it wins over the timeout
        if (waiting) begin
            if (expired) begin
                state_d   = ERROR;
                err_to_d  = 1'b1;
                err_idx_d = idx_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            err_to_q  <= 1'b0;
            err_idx_q <= '0;
            for (int k = 0; k < NUM_WORDS; k++) words_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            err_to_q  <= err_to_d;
            err_idx_q <= err_idx_d;
            if (capture)
                for (int k = 0; k < NUM_WORDS; k++) words_q[k] <= lock_words_i[32*k +: 32];
        end
    end

    // gating with rst_ni drops the request in the same cycle reset is asserted
    assign req       = rst_ni && (state_q == WR || state_q == RD_REQ);
    assign we        = rst_ni && state_q == WR;
    assign bus.req   = req;
    assign bus.we    = we;
    assign bus.addr  = req ? BASE_ADDR + AXI_ADDR_WIDTH'({idx_q, 3'b000}) : '0;
    assign bus.wdata = we ? {32'b0, cur_word} : 64'd0;

    assign busy_o        = state_q == WR || state_q == RD_REQ || state_q == RD_WAIT;
    assign done_o        = state_q == DONE;
    assign err_o         = state_q == ERROR;
    assign err_timeout_o = err_to_q;
    assign err_idx_o     = err_idx_q;
endmodule

// File: tb/tb_reglk_init_seq.sv
// tb_reglk_init_seq: table-driven bench with an echoing slave model; expectations
// follow the build selected by REGLK_INIT_VERIFY_EN.
module tb_reglk_init_seq;
    localparam int NW = 6;
    localparam int TO = 4;
`ifdef REGLK_INIT_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    typedef struct {
        logic [31:0] base;
        int          mode;
        int          ign;
        int          poke;
        logic        done;
        logic        err;
        logic        to;
        logic [4:0]  idx;
        int          cyc;
        int          wr;
        int          rd;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [32*NW-1:0]  words = '0;
    logic              busy, done, err, err_to;
    logic [4:0]        err_idx;

    reglk_init_seq_if #(.AW(64)) bus ();

    reglk_init_seq #(
        .AXI_ADDR_WIDTH(64), .NUM_WORDS(NW), .BASE_ADDR(64'h0), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .lock_words_i(words), .bus(bus),
        .busy_o(busy), .done_o(done), .err_o(err), .err_timeout_o(err_to), .err_idx_o(err_idx)
    );

    always #5 clk = ~clk;

    int          checks = 0, fails = 0;
    logic [63:0] mem [NW];
    int          gmode, ign, wcnt, rcnt, cyc, first_req, miss, rd_idx;
    logic        rd_pend, pw;
    logic [63:0] paddr, pwdata;
    logic [31:0] exp_base;
    vec_t        vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one bus cycle: checks and slave responses happen at the falling edge
    task automatic cycle();
        logic g;
        @(negedge clk);
        cyc++;
        if (pw && bus.req) begin
            chk("addr_stable", bus.addr, paddr);
            chk("wdata_stable", bus.wdata, pwdata);
        end
        bus.rvalid = rd_pend;
        bus.rdata  = (rd_pend && rd_idx < NW) ? mem[rd_idx] : 64'd0;
        rd_pend    = 1'b0;
        g = (gmode == 0) ? 1'b1 : (gmode == 2) ? 1'b0 : (miss >= 2 || $urandom_range(0, 99) < 30);
        bus.gnt = g;
        if (bus.req && g) begin
            miss = 0;
            if (bus.we) begin
                chk("wr_addr", bus.addr, 64'(8 * wcnt));
                chk("wr_data", bus.wdata, {32'b0, exp_base + 32'(wcnt)});
                if (wcnt < NW && wcnt != ign) mem[wcnt] = bus.wdata;
                wcnt++;
            end else begin
                chk("rd_addr", bus.addr, 64'(8 * rcnt));
                rd_pend = 1'b1;
                rd_idx  = rcnt;
                rcnt++;
            end
        end else if (bus.req) miss++;
        else miss = 0;
        pw     = bus.req && !g;
        paddr  = bus.addr;
        pwdata = bus.wdata;
        if (bus.req && first_req < 0) first_req = cyc;
    endtask

    task automatic run(input vec_t v);
        int rd_end;
        wcnt = 0; rcnt = 0; cyc = 0; miss = 0; first_req = -1;
        rd_pend = 1'b0; pw = 1'b0;
        exp_base = v.base; gmode = v.mode; ign = v.ign;
        for (int k = 0; k < NW; k++) begin
            mem[k] = '0;
            words[32*k +: 32] = v.base + 32'(k);
        end
        start = 1'b1;
        cycle();
        for (int i = 0; i < 400 && !(done || err); i++) begin
            if (v.poke > 0 && i == v.poke) begin
                for (int k = 0; k < NW; k++) words[32*k +: 32] = ~v.base + 32'(k);
                start = 1'b1;
            end else start = 1'b0;
            cycle();
        end
        start = 1'b0;
        if (!(done || err)) begin
            fails++;
            $display("FAIL end_bound: no done/err within 400 cycles for base %0h", v.base);
        end
        chk("done", done, v.done);
        chk("err", err, v.err);
        chk("err_timeout", err_to, v.to);
        chk("err_idx", err_idx, v.idx);
        chk("busy_end", busy, 1'b0);
        chk("writes", wcnt, v.wr);
        chk("reads", rcnt, v.rd);
        if (v.cyc >= 0) chk("cycles", cyc - first_req, v.cyc);
        if (v.done)
            for (int k = 0; k < NW; k++)
                if (k != v.ign) chk("mem", mem[k], {32'b0, v.base + 32'(k)});
        rd_end = rcnt;
        cycle();
        cycle();
        chk("req_after", bus.req, 1'b0);
        chk("no_extra_rd", rcnt, rd_end);
        chk("hold_level", {done, err}, {v.done, v.err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
        vecs[0] = '{32'h1111_0000, 0, -1, 0, 1'b1, 1'b0, 1'b0, 5'd0, VER ? 18 : 6, 6, VER ? 6 : 0};
        vecs[1] = '{32'h2222_0000, 0, 2, 0, !VER, VER, 1'b0, VER ? 5'd2 : 5'd0, VER ? 12 : 6, 6, VER ? 3 : 0};
        vecs[2] = '{32'h3333_0000, 2, -1, 0, 1'b0, 1'b1, 1'b1, 5'd0, 4, 0, 0};
        vecs[3] = '{32'h4444_0000, 1, -1, 0, 1'b1, 1'b0, 1'b0, 5'd0, -1, 6, VER ? 6 : 0};
        vecs[4] = '{32'h5555_0000, 1, 5, 0, !VER, VER, 1'b0, VER ? 5'd5 : 5'd0, -1, 6, VER ? 6 : 0};
        vecs[5] = '{32'h7777_0000, 0, -1, 2, 1'b1, 1'b0, 1'b0, 5'd0, VER ? 18 : 6, 6, VER ? 6 : 0};

        repeat (2) @(negedge clk);
        chk("rst_req", bus.req, 1'b0);
        chk("rst_addr", bus.addr, 64'd0);
        chk("rst_flags", {busy, done, err, err_to, err_idx}, 9'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 6; n++) run(vecs[n]);

        // asynchronous reset in the middle of the word-3 access, then a clean rerun
        exp_base = 32'h6666_0000; gmode = 0; ign = -1;
        wcnt = 0; rcnt = 0; cyc = 0; first_req = -1; rd_pend = 1'b0; pw = 1'b0;
        for (int k = 0; k < NW; k++) words[32*k +: 32] = exp_base + 32'(k);
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 60 && !(bus.req && bus.we == !VER && bus.addr == 64'h18); i++) cycle();
        chk("pre_rst_addr", bus.addr, 64'h18);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", bus.req, 1'b0);
        chk("mid_rst_we", bus.we, 1'b0);
        chk("mid_rst_addr", bus.addr, 64'd0);
        chk("mid_rst_wdata", bus.wdata, 64'd0);
        chk("mid_rst_flags", {busy, done, err, err_to, err_idx}, 9'd0);
        #1 rst_n = 1'b1;
        bus.rvalid = 1'b0;
        run(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
